// File: rtl/mac_seq_ctrl.sv
// Command sequencer driving an 8-bit signed MAC with a 2-cycle feedback loop.
// Optional result clipping to SAT_W bits is built when MAC_SEQ_SAT_EN is defined.
`timescale 1ns/1ps

module mac_seq_ctrl #(
    parameter int LEN_W = 8,
    parameter int SAT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_mode,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [7:0]       cmd_bias,
    input  logic [7:0]       cmd_x,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [7:0]       op_a,
    input  logic [7:0]       op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [24:0]      res_data,
    output logic             res_sat,
    output logic [7:0]       mac_in_1,
    output logic [7:0]       mac_in_2,
    output logic [7:0]       mac_in_add,
    output logic             mac_mul_input_mux,
    output logic             mac_adder_input_mux,
    input  logic [24:0]      mac_output
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_BUBBLE,
        S_HOLD,
        S_DRAIN,
        S_RESULT
    } state_t;

`ifdef MAC_SEQ_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic signed [24:0] SAT_MAX = (25'sd1 <<< (SAT_W - 1)) - 25'sd1;
    localparam logic signed [24:0] SAT_MIN = -(25'sd1 <<< (SAT_W - 1));

    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [7:0]         bias_q, bias_d;
    logic [7:0]         x_q, x_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               first_q, first_d;
    logic [24:0]        res_data_q, res_data_d;
    logic               res_sat_q, res_sat_d;

    assign cmd_ready = (state_q == S_IDLE);
    assign op_ready  = (state_q == S_ISSUE);
    assign res_valid = (state_q == S_RESULT);
    assign res_data  = res_data_q;
    assign res_sat   = res_sat_q;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d             = state_q;
        mode_d              = mode_q;
        len_d               = len_q;
        bias_d              = bias_q;
        x_d                 = x_q;
        cnt_d               = cnt_q;
        first_d             = first_q;
        res_data_d          = res_data_q;
        res_sat_d           = res_sat_q;
        mac_in_1            = '0;
        mac_in_2            = '0;
        mac_in_add          = '0;
        mac_mul_input_mux   = 1'b0;
        mac_adder_input_mux = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    mode_d  = cmd_mode;
                    len_d   = cmd_len;
                    bias_d  = cmd_bias;
                    x_d     = cmd_x;
                    cnt_d   = '0;
                    first_d = 1'b1;
                    if (cmd_len == '0) begin
                        res_data_d = cmd_mode ? 25'd0 : {{17{cmd_bias[7]}}, cmd_bias};
                        res_sat_d  = 1'b0;
                        state_d    = S_RESULT;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                if (op_valid) begin
                    if (!mode_q) begin
                        mac_in_1 = op_a;
                        mac_in_2 = op_b;
                        if (first_q) mac_in_add = bias_q;
                        else         mac_adder_input_mux = 1'b1;
                    end else begin
                        mac_in_add = op_a;
                        if (!first_q) begin
                            mac_mul_input_mux = 1'b1;
                            mac_in_2          = x_q;
                        end
                    end
                    cnt_d   = cnt_q + 1'b1;
                    first_d = 1'b0;
                    state_d = S_BUBBLE;
                end else begin
                    // Zero product plus fed-back sum recirculates the accumulator unchanged.
                    mac_adder_input_mux = 1'b1;
                    state_d             = S_HOLD;
                end
            end

            S_HOLD: begin
                mac_adder_input_mux = 1'b1;
                state_d             = S_ISSUE;
            end

            S_BUBBLE: begin
                state_d = (cnt_q == len_q) ? S_DRAIN : S_ISSUE;
            end

            S_DRAIN: begin
                res_data_d = mac_output;
                res_sat_d  = 1'b0;
                if (SAT_EN && ($signed(mac_output) > SAT_MAX)) begin
                    res_data_d = SAT_MAX;
                    res_sat_d  = 1'b1;
                end else if (SAT_EN && ($signed(mac_output) < SAT_MIN)) begin
                    res_data_d = SAT_MIN;
                    res_sat_d  = 1'b1;
                end
                state_d = S_RESULT;
            end

            S_RESULT: begin
                if (res_ready) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            len_q      <= '0;
            bias_q     <= '0;
            x_q        <= '0;
            cnt_q      <= '0;
            first_q    <= 1'b0;
            res_data_q <= '0;
            res_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            len_q      <= len_d;
            bias_q     <= bias_d;
            x_q        <= x_d;
            cnt_q      <= cnt_d;
            first_q    <= first_d;
            res_data_q <= res_data_d;
            res_sat_q  <= res_sat_d;
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl: behavioural 2-stage MAC, reference arithmetic model
// and a result scoreboard. Honours MAC_SEQ_SAT_EN for the expected clipping.
`timescale 1ns/1ps

module tb_mac_seq_ctrl;

    localparam int LEN_W = 8;
    localparam int SAT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid, cmd_ready, cmd_mode;
    logic [LEN_W-1:0] cmd_len;
    logic [7:0]       cmd_bias, cmd_x;
    logic             op_valid, op_ready;
    logic [7:0]       op_a, op_b;
    logic             res_valid, res_ready, res_sat;
    logic [24:0]      res_data;
    logic [7:0]       mac_in_1, mac_in_2, mac_in_add;
    logic             mac_mul_input_mux, mac_adder_input_mux;
    logic [24:0]      mac_output;

    always #5 clk = ~clk;

    mac_seq_ctrl #(.LEN_W(LEN_W), .SAT_W(SAT_W)) dut (
        .clk                 (clk),
        .reset               (reset),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .cmd_mode            (cmd_mode),
        .cmd_len             (cmd_len),
        .cmd_bias            (cmd_bias),
        .cmd_x               (cmd_x),
        .op_valid            (op_valid),
        .op_ready            (op_ready),
        .op_a                (op_a),
        .op_b                (op_b),
        .res_valid           (res_valid),
        .res_ready           (res_ready),
        .res_data            (res_data),
        .res_sat             (res_sat),
        .mac_in_1            (mac_in_1),
        .mac_in_2            (mac_in_2),
        .mac_in_add          (mac_in_add),
        .mac_mul_input_mux   (mac_mul_input_mux),
        .mac_adder_input_mux (mac_adder_input_mux),
        .mac_output          (mac_output)
    );

    // Behavioural MAC: product/addend register, then sum register fed back.
    logic signed [24:0] mac_mul_sel;
    logic signed [32:0] mac_mul_full;
    logic        [23:0] mac_p_q;
    logic        [24:0] mac_a_q, mac_out_q;

    always_comb begin
        mac_mul_sel  = mac_mul_input_mux ? $signed(mac_out_q) : $signed({{17{mac_in_1[7]}}, mac_in_1});
        mac_mul_full = mac_mul_sel * $signed(mac_in_2);
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mac_p_q   <= '0;
            mac_a_q   <= '0;
            mac_out_q <= '0;
        end else begin
            mac_p_q   <= mac_mul_full[23:0];
            mac_a_q   <= mac_adder_input_mux ? mac_out_q : {{17{mac_in_add[7]}}, mac_in_add};
            mac_out_q <= {mac_p_q[23], mac_p_q} + mac_a_q;
        end
    end
    assign mac_output = mac_out_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [24:0] data;
        logic        sat;
    } exp_t;

    exp_t        sb_q[$];
    logic [7:0]  arr_a[8];
    logic [7:0]  arr_b[8];
    int          n_cmp = 0;
    int          n_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [24:0] ref_step(input bit mode, input bit first, input logic [24:0] acc,
                                              input logic [7:0] a, input logic [7:0] b,
                                              input logic [7:0] x, input logic [7:0] bias);
        longint p, s;
        logic [23:0] pt;
        if (!mode) begin
            p  = longint'($signed(a)) * longint'($signed(b));
            pt = p[23:0];
            s  = longint'($signed(pt)) + (first ? longint'($signed(bias)) : longint'($signed(acc)));
        end else if (first) begin
            s = longint'($signed(a));
        end else begin
            p  = longint'($signed(x)) * longint'($signed(acc));
            pt = p[23:0];
            s  = longint'($signed(pt)) + longint'($signed(a));
        end
        return s[24:0];
    endfunction

    function automatic exp_t expect_result(input bit mode, input int n, input logic [7:0] x,
                                           input logic [7:0] bias);
        exp_t   e;
        longint v;
        longint lim;
        logic [24:0] acc;
        acc = mode ? 25'd0 : {{17{bias[7]}}, bias};
        for (int i = 0; i < n; i++) acc = ref_step(mode, i == 0, acc, arr_a[i], arr_b[i], x, bias);
        e.data = acc;
        e.sat  = 1'b0;
        v   = longint'($signed(acc));
        lim = longint'(1) << (SAT_W - 1);
`ifdef MAC_SEQ_SAT_EN
        if (n > 0 && v > lim - 1) begin
            v = lim - 1; e.data = v[24:0]; e.sat = 1'b1;
        end else if (n > 0 && v < -lim) begin
            v = -lim; e.data = v[24:0]; e.sat = 1'b1;
        end
`endif
        return e;
    endfunction

    task automatic send_cmd(input bit mode, input int n, input logic [7:0] bias, input logic [7:0] x,
                            output int acc_cyc);
        int guard;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_mode  = mode;
        cmd_len   = LEN_W'(n);
        cmd_bias  = bias;
        cmd_x     = x;
        #1;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(negedge clk); #1; guard++;
        end
        check("cmd_accept", {31'd0, cmd_ready}, 32'd1);
        acc_cyc = cyc;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic feed(input bit mode, input int n, input logic [7:0] bias, input logic [7:0] x,
                        input int stall_idx, input int stall_len);
        int idx, left, guard, last_cyc;
        bit started;
        logic [24:0] acc;
        idx = 0; left = stall_len; guard = 0; last_cyc = -1; started = 1'b0;
        acc = '0;
        while (idx < n && guard < 200) begin
            @(negedge clk);
            guard++;
            if (idx == stall_idx && left > 0 && (started || op_ready)) begin
                started  = 1'b1;
                left--;
                op_valid = 1'b0;
            end else begin
                op_valid = 1'b1;
                op_a     = arr_a[idx];
                op_b     = arr_b[idx];
            end
            #1;
            if (op_ready && idx > 0) check("partial_acc", {7'd0, mac_output}, {7'd0, acc});
            if (op_ready && op_valid) begin
                if (last_cyc >= 0 && stall_len == 0) check("beat_gap", cyc - last_cyc, 32'd2);
                last_cyc = cyc;
                acc = ref_step(mode, idx == 0, acc, arr_a[idx], arr_b[idx], x, bias);
                idx++;
            end
        end
        if (idx < n) check("feed_timeout", idx, n);
    endtask

    task automatic wait_valid(output int at_cyc);
        int guard;
        guard = 0;
        @(negedge clk); #1;
        while (!res_valid && guard < 100) begin
            @(negedge clk); #1; guard++;
        end
        if (!res_valid) check("res_timeout", {31'd0, res_valid}, 32'd1);
        at_cyc = cyc;
    endtask

    task automatic collect(input int hold_cycles);
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = sb_q[0];
        for (int i = 0; i < hold_cycles; i++) begin
            @(negedge clk); #1;
            check("hold_valid", {31'd0, res_valid}, 32'd1);
            check("hold_data", {7'd0, res_data}, {7'd0, e.data});
            check("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        end
        res_ready = 1'b1;
        #1;
        e = sb_q.pop_front();
        check("res_data", {7'd0, res_data}, {7'd0, e.data});
        check("res_sat", {31'd0, res_sat}, {31'd0, e.sat});
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("idle_after_res", {30'd0, cmd_ready, res_valid}, 32'd2);
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, {15'd0, cmd_ready, op_ready, res_valid, res_sat, mac_in_1 | mac_in_2 | mac_in_add,
                    mac_mul_input_mux, mac_adder_input_mux, 3'd0},
              32'h0001_0000);
        check({tag, "_data"}, {7'd0, res_data}, 32'd0);
    endtask

    int acc_c, res_c, guard;

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_len = '0; cmd_bias = '0; cmd_x = '0;
        op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1 check_reset_outputs("reset_state");
        reset = 1'b0;

        // DOT bias=5: (2,3),(-4,5),(7,7) -> 40, result 8 cycles after acceptance
        arr_a[0] = 8'sd2;  arr_b[0] = 8'sd3;
        arr_a[1] = -8'sd4; arr_b[1] = 8'sd5;
        arr_a[2] = 8'sd7;  arr_b[2] = 8'sd7;
        sb_q.push_back(expect_result(1'b0, 3, 8'd0, 8'sd5));
        check("dot_model", {7'd0, sb_q[0].data}, 32'd40);
        send_cmd(1'b0, 3, 8'sd5, 8'd0, acc_c);
        feed(1'b0, 3, 8'sd5, 8'd0, -1, 0);
        wait_valid(res_c);
        check("dot_latency", res_c - acc_c, 32'd8);
        collect(0);

        // HORNER x=2: 1,-3,4 -> 2 with intermediates 1, -1
        arr_a[0] = 8'sd1; arr_a[1] = -8'sd3; arr_a[2] = 8'sd4;
        sb_q.push_back(expect_result(1'b1, 3, 8'sd2, 8'd0));
        send_cmd(1'b1, 3, 8'd0, 8'sd2, acc_c);
        feed(1'b1, 3, 8'd0, 8'sd2, -1, 0);
        wait_valid(res_c);
        check("horner_latency", res_c - acc_c, 32'd8);
        collect(0);

        // Same DOT with a 3-cycle stall before the second pair -> 4 cycles later
        arr_a[0] = 8'sd2;  arr_b[0] = 8'sd3;
        arr_a[1] = -8'sd4; arr_b[1] = 8'sd5;
        arr_a[2] = 8'sd7;  arr_b[2] = 8'sd7;
        sb_q.push_back(expect_result(1'b0, 3, 8'd0, 8'sd5));
        send_cmd(1'b0, 3, 8'sd5, 8'd0, acc_c);
        feed(1'b0, 3, 8'sd5, 8'd0, 1, 3);
        wait_valid(res_c);
        check("stall_latency", res_c - acc_c, 32'd12);
        collect(0);

        // Result backpressure for 5 cycles; product -128*-128 exercises sign handling
        arr_a[0] = 8'sd10;   arr_b[0] = -8'sd3;
        arr_a[1] = -8'sd128; arr_b[1] = -8'sd128;
        sb_q.push_back(expect_result(1'b0, 2, 8'd0, -8'sd1));
        send_cmd(1'b0, 2, -8'sd1, 8'd0, acc_c);
        feed(1'b0, 2, -8'sd1, 8'd0, -1, 0);
        wait_valid(res_c);
        collect(5);

        // DOT len=0, bias=-7 -> sign-extended bias, no operand consumed
        op_valid = 1'b1;
        sb_q.push_back(expect_result(1'b0, 0, 8'd0, -8'sd7));
        check("len0_model", {7'd0, sb_q[0].data}, 32'h01FF_FFF9);
        send_cmd(1'b0, 0, -8'sd7, 8'd0, acc_c);
        @(negedge clk); #1;
        check("len0_op_ready", {31'd0, op_ready}, 32'd0);
        check("len0_valid", {31'd0, res_valid}, 32'd1);
        collect(0);

        // Reset in the middle of ISSUE of a len=4 command
        arr_a[0] = 8'sd3; arr_b[0] = 8'sd3;
        send_cmd(1'b0, 4, 8'sd1, 8'd0, acc_c);
        op_valid = 1'b1; op_a = 8'sd3; op_b = 8'sd3;
        guard = 0;
        @(negedge clk); #1;
        while (!op_ready && guard < 20) begin
            @(negedge clk); #1; guard++;
        end
        @(negedge clk); #1;
        guard = 0;
        while (!op_ready && guard < 20) begin
            @(negedge clk); #1; guard++;
        end
        op_a = 8'sd5;
        #1;
        check("pre_reset_issue", {24'd0, mac_in_1}, 32'd5);
        reset = 1'b1;
        #1 check_reset_outputs("mid_reset");
        op_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        arr_a[0] = 8'sd1; arr_a[1] = -8'sd3; arr_a[2] = 8'sd4;
        sb_q.push_back(expect_result(1'b1, 3, 8'sd2, 8'd0));
        send_cmd(1'b1, 3, 8'd0, 8'sd2, acc_c);
        feed(1'b1, 3, 8'd0, 8'sd2, -1, 0);
        wait_valid(res_c);
        collect(0);

        // DOT bias=0, (127,127)x4 -> 64516 raw, 32767 with clipping
        for (int i = 0; i < 4; i++) begin
            arr_a[i] = 8'sd127; arr_b[i] = 8'sd127;
        end
        sb_q.push_back(expect_result(1'b0, 4, 8'd0, 8'd0));
`ifdef MAC_SEQ_SAT_EN
        check("sat_model", {7'd0, sb_q[0].data}, 32'd32767);
`else
        check("sat_model", {7'd0, sb_q[0].data}, 32'd64516);
`endif
        send_cmd(1'b0, 4, 8'd0, 8'd0, acc_c);
        feed(1'b0, 4, 8'd0, 8'd0, -1, 0);
        wait_valid(res_c);
        check("len4_latency", res_c - acc_c, 32'd10);
        collect(0);

        check("sb_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
